// File: rtl/inst_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher and its cache.
// FET_JAL_PREDICT_EN (optional define) enables static JAL target redirection.
package inst_fetcher_pkg;

    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;

    localparam word_t      ZERO_WORD     = '0;
    localparam word_t      PC_ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic       TRUE          = 1'b1;
    localparam logic       FALSE         = 1'b0;
    localparam logic [6:0] JAL_OPCODE    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2
    } fet_state_e;

    // J-type immediate; only bits [31:12] of the instruction carry it.
    function automatic word_t jal_imm(input logic [31:12] inst_hi);
        return {{11{inst_hi[31]}}, inst_hi[31], inst_hi[19:12], inst_hi[20],
                inst_hi[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fet_icache.sv
// Direct-mapped instruction cache, one word per line: combinational hit/data
// read port and a registered fill port. Only rst clears the valid bits.
module fet_icache
    import inst_fetcher_pkg::*;
#(
    parameter  int IDX_W = 6,
    localparam int TAG_W = WORD_W - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             rd_hit_o,
    output word_t            rd_data_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  word_t            wr_data_i
);

    localparam int LINES = 2 ** IDX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    word_t            data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_idx_i] <= TRUE;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_hit_o  = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/inst_fetcher.sv
// Front-end fetch stage: PC, I-cache miss handling and one-per-cycle issue.
// Define FET_JAL_PREDICT_EN to redirect the PC to JAL targets at issue time.
module inst_fetcher
    import inst_fetcher_pkg::*;
#(
    parameter int    ICACHE_IDX_W = 6,
    parameter word_t RESET_PC     = 32'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    output logic       mc_req_out,
    output word_t      mc_addr_out,
    input  logic       mc_ack_in,
    input  word_t      mc_data_in,
    input  logic       dis_stall_in,
    input  logic       rob_flush_in,
    input  word_t      rob_target_pc_in,
    output logic       dec_issue_out,
    output word_t      dec_inst_out,
    output word_t      dec_pc_out,
    output fet_state_e dbg_state_out
);

    localparam int TAG_W = WORD_W - ICACHE_IDX_W - 2;

    fet_state_e state_q;
    word_t      pc_q;
    logic       mc_req_q;
    word_t      mc_addr_q;
    logic       issue_q;
    word_t      inst_q;
    word_t      ipc_q;

    logic       hit;
    word_t      line_data;
    logic       fill_en;
    word_t      pc_seq_d;

    // Fills land even after a flush: the requested address is still a real line.
    assign fill_en = rdy && (state_q != IDLE) && mc_ack_in;

    fet_icache #(.IDX_W(ICACHE_IDX_W)) u_icache (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (pc_q[ICACHE_IDX_W+1:2]),
        .rd_tag_i  (pc_q[WORD_W-1:ICACHE_IDX_W+2]),
        .rd_hit_o  (hit),
        .rd_data_o (line_data),
        .wr_en_i   (fill_en),
        .wr_idx_i  (mc_addr_q[ICACHE_IDX_W+1:2]),
        .wr_tag_i  (mc_addr_q[WORD_W-1:ICACHE_IDX_W+2]),
        .wr_data_i (mc_data_in)
    );

    always_comb begin
        pc_seq_d = pc_q + 32'd4;
`ifdef FET_JAL_PREDICT_EN
        if (line_data[6:0] == JAL_OPCODE) begin
            pc_seq_d = (pc_q + jal_imm(line_data[31:12])) & PC_ALIGN_MASK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC & PC_ALIGN_MASK;
            mc_req_q  <= FALSE;
            mc_addr_q <= ZERO_WORD;
            issue_q   <= FALSE;
            inst_q    <= ZERO_WORD;
            ipc_q     <= ZERO_WORD;
        end else if (!rdy) begin
            issue_q <= FALSE;
        end else begin
            issue_q <= FALSE;
            if (rob_flush_in) begin
                pc_q <= rob_target_pc_in & PC_ALIGN_MASK;
                if (state_q != IDLE) begin
                    // An outstanding request must still complete before new fetches.
                    if (mc_ack_in) begin
                        mc_req_q <= FALSE;
                        state_q  <= IDLE;
                    end else begin
                        state_q <= DISCARD;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (hit) begin
                            if (!dis_stall_in) begin
                                issue_q <= TRUE;
                                inst_q  <= line_data;
                                ipc_q   <= pc_q;
                                pc_q    <= pc_seq_d;
                            end
                        end else begin
                            mc_req_q  <= TRUE;
                            mc_addr_q <= pc_q;
                            state_q   <= WAIT_MEM;
                        end
                    end
                    WAIT_MEM, DISCARD: begin
                        if (mc_ack_in) begin
                            mc_req_q <= FALSE;
                            state_q  <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign mc_req_out    = mc_req_q;
    assign mc_addr_out   = mc_addr_q;
    assign dec_issue_out = issue_q;
    assign dec_inst_out  = inst_q;
    assign dec_pc_out    = ipc_q;
    assign dbg_state_out = state_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with an issue-stream model and memory responder.
module tb_inst_fetcher;
  import inst_fetcher_pkg::*;

`ifdef FET_JAL_PREDICT_EN
  localparam bit JAL_PRED = 1'b1;
`else
  localparam bit JAL_PRED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        mc_req_out;
  logic [31:0] mc_addr_out;
  logic        mc_ack_in = 1'b0;
  logic [31:0] mc_data_in = '0;
  logic        dis_stall_in = 1'b0;
  logic        rob_flush_in = 1'b0;
  logic [31:0] rob_target_pc_in = '0;
  logic        dec_issue_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  fet_state_e  dbg_state_out;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 3;
  bit mem_hold = 1'b0;
  int wait_cnt = 0;

  // Model state: the next PC the issue stream must show.
  logic [31:0] exp_pc = '0;
  bit          no_issue_exp = 1'b1;
  logic        req_prev = 1'b0;

  inst_fetcher dut (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .mc_req_out       (mc_req_out),
    .mc_addr_out      (mc_addr_out),
    .mc_ack_in        (mc_ack_in),
    .mc_data_in       (mc_data_in),
    .dis_stall_in     (dis_stall_in),
    .rob_flush_in     (rob_flush_in),
    .rob_target_pc_in (rob_target_pc_in),
    .dec_issue_out    (dec_issue_out),
    .dec_inst_out     (dec_inst_out),
    .dec_pc_out       (dec_pc_out),
    .dbg_state_out    (dbg_state_out)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- memory image ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)  return 32'h00100093;
    if (a == 32'h20) return 32'h030000EF;  // jal x1, +0x30
    return {a[15:0], 16'h0013};
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] inst);
    logic signed [20:0] j;
    int off;
    j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    off = j;
    if (JAL_PRED && inst[6:0] == 7'h6F) return (pc + 32'(off)) & 32'hFFFF_FFFC;
    return pc + 32'd4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    rob_flush_in = 1'b0;
    if (mc_ack_in) begin
      mc_ack_in = 1'b0;
      wait_cnt  = 0;
    end else if (mc_req_out && rdy && !mem_hold) begin
      wait_cnt++;
      if (wait_cnt >= mem_lat) begin
        mc_ack_in  = 1'b1;
        mc_data_in = mem_word(mc_addr_out);
      end
    end
  endtask

  task automatic flush_to(input logic [31:0] target);
    rob_flush_in     = 1'b1;
    rob_target_pc_in = target;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mc_req_out && n < 40) begin step(); n++; end
    chk({name, "_req_timeout"}, 32'(mc_req_out), 32'd1);
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    while (!mc_ack_in && n < 40) begin step(); n++; end
    chk({name, "_ack_timeout"}, 32'(mc_ack_in), 32'd1);
  endtask

  task automatic wait_issue(input logic [31:0] pc, input string name);
    int n = 0;
    while (!(dec_issue_out && dec_pc_out == pc) && n < 200) begin step(); n++; end
    chk({name, "_issue_timeout"}, 32'(n < 200), 32'd1);
  endtask

  task automatic wait_next_issue(input string name);
    int n = 0;
    do begin step(); n++; end while (!dec_issue_out && n < 60);
    chk({name, "_next_issue_timeout"}, 32'(dec_issue_out), 32'd1);
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    #1;
    if (no_issue_exp) chk("model_no_issue", 32'(dec_issue_out), 32'd0);
    if (dec_issue_out) begin
      chk("model_issue_pc", dec_pc_out, exp_pc);
      chk("model_issue_inst", dec_inst_out, mem_word(dec_pc_out));
      exp_pc = model_next(dec_pc_out, dec_inst_out);
    end
    if (mc_req_out && !req_prev) begin
      chk("model_req_addr", mc_addr_out, exp_pc);
    end
    req_prev = mc_req_out;
    // Inputs now settled for the coming edge.
    if (rst) begin
      exp_pc = 32'h0;
      no_issue_exp = 1'b1;
    end else if (!rdy) begin
      no_issue_exp = 1'b1;
    end else if (rob_flush_in) begin
      exp_pc = rob_target_pc_in & 32'hFFFF_FFFC;
      no_issue_exp = 1'b1;
    end else begin
      no_issue_exp = dis_stall_in;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [31:0] got_q[$];
    logic [31:0] held_addr;
    int req_cycles;

    step(); step();
    chk("reset_req", 32'(mc_req_out), 32'd0);
    chk("reset_addr", mc_addr_out, 32'h0);
    chk("reset_issue", 32'(dec_issue_out), 32'd0);
    chk("reset_inst", dec_inst_out, 32'h0);
    chk("reset_pc", dec_pc_out, 32'h0);
    chk("reset_state", 32'(dbg_state_out), 32'(IDLE));
    rst = 1'b0;

    // Cold start: miss at 0, issue two cycles after the ack.
    wait_req("cold");
    chk("cold_addr", mc_addr_out, 32'h0);
    wait_ack("cold");
    step();
    chk("cold_no_issue_after_ack", 32'(dec_issue_out), 32'd0);
    step();
    chk("cold_issue", 32'(dec_issue_out), 32'd1);
    chk("cold_inst", dec_inst_out, 32'h00100093);
    chk("cold_pc", dec_pc_out, 32'h0);
    wait_req("cold_next");
    chk("cold_next_addr", mc_addr_out, 32'h4);

    // Warm loop over lines 0..3.
    wait_issue(32'hC, "fill12");
    flush_to(32'h0);
    req_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (mc_req_out) req_cycles++;
      if (dec_issue_out) got_q.push_back(dec_pc_out);
    end
    chk("warm_req_cycles", 32'(req_cycles), 32'd0);
    chk("warm_issue_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("warm_pc", got_q[i], 32'(4 * i));

    // Stall for 5 cycles with pc sitting at 8.
    flush_to(32'h0);
    wait_issue(32'h4, "stall_pre");
    dis_stall_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_no_issue", 32'(dec_issue_out), 32'd0);
    end
    dis_stall_in = 1'b0;
    step();
    chk("stall_release_issue", 32'(dec_issue_out), 32'd1);
    chk("stall_release_pc", dec_pc_out, 32'h8);

    // Flush while a miss is outstanding.
    wait_issue(32'hC, "miss_pre");
    mem_hold = 1'b1;
    wait_req("miss16");
    chk("miss16_addr", mc_addr_out, 32'h10);
    chk("miss16_state", 32'(dbg_state_out), 32'(WAIT_MEM));
    flush_to(32'h40);
    step();
    chk("discard_state", 32'(dbg_state_out), 32'(DISCARD));
    chk("discard_req_held", 32'(mc_req_out), 32'd1);
    chk("discard_addr_held", mc_addr_out, 32'h10);
    mem_hold = 1'b0;
    wait_ack("discard");
    step();
    chk("discard_done_state", 32'(dbg_state_out), 32'(IDLE));
    chk("discard_no_issue", 32'(dec_issue_out), 32'd0);
    wait_req("redirect40");
    chk("redirect40_addr", mc_addr_out, 32'h40);
    wait_issue(32'h40, "redirect40");
    flush_to(32'h10);
    step();
    chk("fill_kept_req0", 32'(mc_req_out), 32'd0);
    step();
    chk("fill_kept_req1", 32'(mc_req_out), 32'd0);
    chk("fill_kept_issue", 32'(dec_issue_out), 32'd1);
    chk("fill_kept_pc", dec_pc_out, 32'h10);

    // Flush in the same cycle as the ack.
    mem_hold = 1'b1;
    wait_req("miss14");
    chk("miss14_addr", mc_addr_out, 32'h14);
    step();
    mc_ack_in  = 1'b1;
    mc_data_in = mem_word(mc_addr_out);
    flush_to(32'h100);
    step();
    chk("simack_state", 32'(dbg_state_out), 32'(IDLE));
    chk("simack_req", 32'(mc_req_out), 32'd0);
    chk("simack_no_issue", 32'(dec_issue_out), 32'd0);
    mem_hold = 1'b0;
    wait_req("redirect100");
    chk("redirect100_addr", mc_addr_out, 32'h100);
    wait_issue(32'h100, "redirect100");

    // JAL at 0x20 with +0x30 offset.
    flush_to(32'h20);
    wait_issue(32'h20, "jal");
    chk("jal_inst", dec_inst_out, 32'h030000EF);
    wait_next_issue("jal");
    chk("jal_next_pc", dec_pc_out, JAL_PRED ? 32'h50 : 32'h24);

    // Global freeze while a request is pending.
    wait_req("freeze");
    held_addr = mc_addr_out;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("freeze_req", 32'(mc_req_out), 32'd1);
      chk("freeze_addr", mc_addr_out, held_addr);
      chk("freeze_issue", 32'(dec_issue_out), 32'd0);
    end
    rdy = 1'b1;
    wait_issue(held_addr, "freeze_resume");

    step(); step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetcher.md
Name: inst_fetcher

Overview:
- Front-end stage of the Tomasulo core. Holds the PC and a direct-mapped instruction cache.
- Fetches 32-bit instruction words from the memory controller on a miss.
- Presents one instruction per issue pulse to the decoder, which is combinational.
- Honours back-pressure from the dispatch side and redirects on ROB flush (branch mispredict or JALR).

Parameters:
- ICACHE_IDX_W, 6, log2 of cache lines; 64 lines, one 32-bit word per line.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- mc_req_out  out  1  instruction-fetch request; held high until ack.
- mc_addr_out  out  32  word address of the request, {pc[31:2],2'b00}.
- mc_ack_in  in  1  one-cycle pulse; mc_data_in valid this cycle.
- mc_data_in  in  32  fetched instruction word, little-endian assembled.
- dis_stall_in  in  1  RS, LSB or ROB cannot accept; do not issue.
- rob_flush_in  in  1  redirect pulse.
- rob_target_pc_in  in  32  redirect PC, valid with flush.
- dec_issue_out  out  1  one-cycle issue pulse to decoder.
- dec_inst_out  out  32  instruction word, stable while issue high.
- dec_pc_out  out  32  PC of the issued instruction.

Behaviour:
- Priority each cycle: rst > !rdy > rob_flush_in > normal operation.
- Reset values:
  - pc=RESET_PC; state=IDLE; all valid bits 0.
  - mc_req_out=0; mc_addr_out=0.
  - dec_issue_out=0; dec_inst_out=0; dec_pc_out=0.
- Cache addressing: index=pc[ICACHE_IDX_W+1:2]; tag=pc[31:ICACHE_IDX_W+2]. Valid bits are cleared only by rst, never by flush.
- All outputs are registered. dec_issue_out is cleared every cycle unless re-asserted.
- State IDLE:
  - Hit and !dis_stall_in: next cycle dec_issue_out=1, dec_inst_out=line data, dec_pc_out=pc; pc<=pc+4. Hit-to-issue latency is 1 cycle; back-to-back hits give one issue per cycle.
  - Hit and stall: no issue; pc held.
  - Miss: mc_req_out<=1, mc_addr_out<=pc; go to WAIT_MEM. A miss while stalled still requests (prefetch).
- State WAIT_MEM:
  - On mc_ack_in: write data, tag and valid into the line for mc_addr_out; mc_req_out<=0; go to IDLE.
  - The next IDLE cycle hits, so miss-to-issue is ack+2 cycles. No issue is made directly from the ack.
- State DISCARD: entered on a flush while in WAIT_MEM without ack.
  - mc_req_out stays high until mc_ack_in.
  - On ack: the fill is still written (the address is valid); go to IDLE. No issue.
- Flush:
  - pc<=rob_target_pc_in; dec_issue_out<=0 the next cycle.
  - From IDLE: stay in IDLE.
  - From WAIT_MEM with simultaneous ack: perform the fill, then go to IDLE.
  - From WAIT_MEM without ack: go to DISCARD.
  - From DISCARD: update pc and stay in DISCARD.
- A stall arriving the same cycle as a hit blocks that issue. An issue already on the outputs is not retracted.
- !rdy: all registers hold, including mc_req_out; dec_issue_out is forced to 0 for the frozen cycles.
- PC arithmetic wraps modulo 2^32. pc[1:0] is always 00 (the target's low bits are masked).

Optional Feature:
- FET_JAL_PREDICT_EN:
  - Defined: on issuing an instruction with opcode 7'b1101111 (JAL), pc<=pc+immJ instead of pc+4. immJ is the sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}. The ROB then must not flush on JAL.
  - Undefined: JAL proceeds with pc+4 like any other instruction; the ROB flush corrects it.

Decomposition:
- Shared header: JAL_OPCODE, WORD_RANGE, ZERO_WORD, TRUE/FALSE, and fetcher state encodings IDLE/WAIT_MEM/DISCARD.
- Sub-module fet_icache: tag/data/valid arrays, a combinational hit/data read port, and a registered write port.
- FSM, PC and issue logic stay in inst_fetcher.

Test Plan:
- Cold start, RESET_PC=0, memory returns 0x00100093 after 3 cycles:
  - mc_req_out=1 with addr 0.
  - dec_issue_out pulses 2 cycles after ack with inst 0x00100093, pc 0.
  - Next request has addr 4.
- Warm loop: preload lines 0..3, no stall -> four consecutive issue pulses, pcs 0,4,8,12, no mc_req_out.
- Stall: dis_stall_in=1 for 5 cycles mid-stream -> no issue; pc held at 8. First issue after release has pc 8.
- Flush during miss: flush to 0x40 while WAIT_MEM before ack -> state DISCARD; line for the old address filled on ack; no issue of old data. Next request has addr 0x40.
- Flush with simultaneous ack: flush target 0x100 -> fill written, next request has addr 0x100, no spurious issue.
- FET_JAL_PREDICT_EN defined, JAL at 0x20 with imm +0x30 issued -> next issued pc is 0x50. Undefined -> next issued pc is 0x24.
